// File: rtl/pe_id_config_sequencer_if.sv
// Config-scan write bus between the ID config sequencer (master) and the PE array (slave).
interface pe_id_config_sequencer_if #(
  parameter int DATA_W = 5
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_net;
  logic [1:0]        cfg_kind;
  logic [2:0]        cfg_row;
  logic [3:0]        cfg_col;
  logic [DATA_W-1:0] cfg_data;

  modport master (
    output cfg_valid, cfg_net, cfg_kind, cfg_row, cfg_col, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_net, cfg_kind, cfg_row, cfg_col, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/pe_id_config_sequencer.sv
// Walks the GIN/GON YID/XID tables for nets 0..3 and then the LN word, one write per handshake.
// Optional macro ID_SNAPSHOT_EN: capture the tables and LN word at start instead of reading them live.
module pe_id_config_sequencer #(
  parameter int NUM_ROWS = 6,
  parameter int NUM_COLS = 8,
  parameter int XID_W    = 5,
  parameter int YID_W    = 3,
  parameter int LN_W     = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [2:0]                            array_h,
  input  logic [3:0]                            array_w,
  input  logic [4*NUM_ROWS*NUM_COLS*XID_W-1:0]  xid_flat,
  input  logic [4*NUM_ROWS*YID_W-1:0]           yid_flat,
  input  logic [LN_W-1:0]                       ln_config,
  pe_id_config_sequencer_if.master              cfg,
  output logic                                  busy,
  output logic                                  done
);

  localparam int XT_W = 4*NUM_ROWS*NUM_COLS*XID_W;
  localparam int YT_W = 4*NUM_ROWS*YID_W;

  typedef enum logic [2:0] {S_IDLE, S_YID, S_XID, S_LN, S_FIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] net_q, net_d;
  logic [2:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [2:0] h_q, h_d;
  logic [3:0] w_q, w_d;
  logic       load;

  logic [1:0] net_o_q, kind_o_q, net_nx, kind_nx;
  logic [2:0] row_o_q, row_nx;
  logic [3:0] col_o_q, col_nx;
  logic [4:0] data_o_q, data_nx;

  logic       valid;
  logic       hs;
  logic [2:0] h_lim;
  logic [3:0] w_lim;

  logic [XT_W-1:0]  xid_src;
  logic [YT_W-1:0]  yid_src;
  logic [LN_W-1:0]  ln_src;
  logic [XID_W-1:0] xid_sel;
  logic [YID_W-1:0] yid_sel;

  assign h_lim = (array_h > 3'(NUM_ROWS)) ? 3'(NUM_ROWS) : array_h;
  assign w_lim = (array_w > 4'(NUM_COLS)) ? 4'(NUM_COLS) : array_w;
  assign hs    = valid && cfg.cfg_ready;

`ifdef ID_SNAPSHOT_EN
  logic [XT_W-1:0] xid_snap_q;
  logic [YT_W-1:0] yid_snap_q;
  logic [LN_W-1:0] ln_snap_q;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      xid_snap_q <= xid_flat;
      yid_snap_q <= yid_flat;
      ln_snap_q  <= ln_config;
    end
  end

  // The first item is loaded on the start edge itself, before the snapshot exists.
  assign xid_src = (state_q == S_IDLE) ? xid_flat  : xid_snap_q;
  assign yid_src = (state_q == S_IDLE) ? yid_flat  : yid_snap_q;
  assign ln_src  = (state_q == S_IDLE) ? ln_config : ln_snap_q;
`else
  assign xid_src = xid_flat;
  assign yid_src = yid_flat;
  assign ln_src  = ln_config;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      net_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      h_q      <= '0;
      w_q      <= '0;
      net_o_q  <= '0;
      kind_o_q <= '0;
      row_o_q  <= '0;
      col_o_q  <= '0;
      data_o_q <= '0;
    end else begin
      state_q <= state_d;
      net_q   <= net_d;
      row_q   <= row_d;
      col_q   <= col_d;
      h_q     <= h_d;
      w_q     <= w_d;
      if (load) begin
        net_o_q  <= net_nx;
        kind_o_q <= kind_nx;
        row_o_q  <= row_nx;
        col_o_q  <= col_nx;
        data_o_q <= data_nx;
      end
    end
  end

  // Indices always name the item presented on the bus; a handshake steps them to the next item.
  always_comb begin
    state_d = state_q;
    net_d   = net_q;
    row_d   = row_q;
    col_d   = col_q;
    h_d     = h_q;
    w_d     = w_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          h_d     = h_lim;
          w_d     = w_lim;
          net_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = (h_lim == 3'd0 || w_lim == 4'd0) ? S_LN : S_YID;
          load    = 1'b1;
        end
      end
      S_YID: begin
        if (hs) begin
          load = 1'b1;
          if (row_q == h_q - 3'd1) begin
            row_d   = '0;
            state_d = S_XID;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      S_XID: begin
        if (hs) begin
          load = 1'b1;
          if (col_q == w_q - 4'd1) begin
            col_d = '0;
            if (row_q == h_q - 3'd1) begin
              row_d = '0;
              if (net_q == 2'd3) begin
                state_d = S_LN;
              end else begin
                net_d   = net_q + 2'd1;
                state_d = S_YID;
              end
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      S_LN: begin
        if (hs) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xid_sel = xid_src[((int'(net_d)*NUM_ROWS + int'(row_d))*NUM_COLS + int'(col_d))*XID_W +: XID_W];
    yid_sel = yid_src[(int'(net_d)*NUM_ROWS + int'(row_d))*YID_W +: YID_W];
    net_nx  = net_d;
    kind_nx = 2'd0;
    row_nx  = row_d;
    col_nx  = 4'd0;
    data_nx = 5'(yid_sel);
    case (state_d)
      S_XID: begin
        kind_nx = 2'd1;
        col_nx  = col_d;
        data_nx = 5'(xid_sel);
      end
      S_LN: begin
        kind_nx = 2'd2;
        net_nx  = 2'd0;
        row_nx  = 3'd0;
        data_nx = 5'(ln_src);
      end
      default: ;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_YID, S_XID, S_LN: begin
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign cfg.cfg_valid = valid;
  assign cfg.cfg_net   = net_o_q;
  assign cfg.cfg_kind  = kind_o_q;
  assign cfg.cfg_row   = row_o_q;
  assign cfg.cfg_col   = col_o_q;
  assign cfg.cfg_data  = data_o_q;

endmodule

// File: tb/tb_pe_id_config_sequencer.sv
// Table-driven bench for pe_id_config_sequencer with a write-sequence scoreboard.
module tb_pe_id_config_sequencer;
  localparam int NR = 6;
  localparam int NC = 8;
  localparam int XW = 5;
  localparam int YW = 3;
  localparam int LW = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [2:0]             array_h = '0;
  logic [3:0]             array_w = '0;
  logic [4*NR*NC*XW-1:0]  xid_flat = '0;
  logic [4*NR*YW-1:0]     yid_flat = '0;
  logic [LW-1:0]          ln_config = '0;
  logic                   busy;
  logic                   done;

  pe_id_config_sequencer_if #(.DATA_W(5)) cfg_bus ();

  pe_id_config_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .array_h   (array_h),
    .array_w   (array_w),
    .xid_flat  (xid_flat),
    .yid_flat  (yid_flat),
    .ln_config (ln_config),
    .cfg       (cfg_bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int net;
    int kind;
    int row;
    int col;
    int data;
  } wr_t;

  typedef struct {
    int h;
    int w;
    int mode;
    int exp_n;
    int poke;
  } vec_t;

  logic [XW-1:0] xt [4][NR][NC];
  logic [YW-1:0] yt [4][NR];
  wr_t           exp_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic pack_tables();
    for (int n = 0; n < 4; n++)
      for (int r = 0; r < NR; r++) begin
        yid_flat[(n*NR+r)*YW +: YW] = yt[n][r];
        for (int c = 0; c < NC; c++)
          xid_flat[((n*NR+r)*NC+c)*XW +: XW] = xt[n][r][c];
      end
  endtask

  task automatic rand_tables();
    for (int n = 0; n < 4; n++)
      for (int r = 0; r < NR; r++) begin
        yt[n][r] = YW'($urandom);
        for (int c = 0; c < NC; c++) xt[n][r][c] = XW'($urandom);
      end
    ln_config = LW'($urandom);
    pack_tables();
  endtask

  task automatic flip_tables();
    for (int n = 0; n < 4; n++)
      for (int r = 0; r < NR; r++) begin
        yt[n][r] = ~yt[n][r];
        for (int c = 0; c < NC; c++) xt[n][r][c] = ~xt[n][r][c];
      end
    ln_config = ~ln_config;
    pack_tables();
  endtask

  task automatic build_expected(input int h, input int w);
    int hh;
    int ww;
    wr_t e;
    hh = (h > NR) ? NR : h;
    ww = (w > NC) ? NC : w;
    exp_q.delete();
    if (hh > 0 && ww > 0) begin
      for (int n = 0; n < 4; n++) begin
        for (int r = 0; r < hh; r++) begin
          e = '{net: n, kind: 0, row: r, col: 0, data: int'(yt[n][r])};
          exp_q.push_back(e);
        end
        for (int r = 0; r < hh; r++)
          for (int c = 0; c < ww; c++) begin
            e = '{net: n, kind: 1, row: r, col: c, data: int'(xt[n][r][c])};
            exp_q.push_back(e);
          end
      end
    end
    e = '{net: 0, kind: 2, row: 0, col: 0, data: int'(ln_config)};
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, int'(cfg_bus.cfg_valid), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_net"},   int'(cfg_bus.cfg_net), 0);
    chk({tag, "_kind"},  int'(cfg_bus.cfg_kind), 0);
    chk({tag, "_row"},   int'(cfg_bus.cfg_row), 0);
    chk({tag, "_col"},   int'(cfg_bus.cfg_col), 0);
    chk({tag, "_data"},  int'(cfg_bus.cfg_data), 0);
  endtask

  // Called at #1 after a posedge with the DUT idle; returns at #1 after the posedge following FIN.
  task automatic run_seq(input int h, input int w, input int mode, input int exp_n,
                         input int poke, input int mutate_at);
    int  hs;
    int  stalls;
    bit  stalled;
    bit  fin_seen;
    wr_t held;
    wr_t e;
    hs = 0; stalls = 0; stalled = 0; fin_seen = 0;
    held = '{0, 0, 0, 0, 0};
    array_h = 3'(h);
    array_w = 4'(w);
    build_expected(h, w);
    cfg_bus.cfg_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 4000; c++) begin
      cfg_bus.cfg_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke != 0 && (c == 3 || c == exp_n + 1)) ? 1'b1 : 1'b0;
      if (mutate_at != 0 && c == mutate_at) flip_tables();
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold_net",  int'(cfg_bus.cfg_net),  held.net);
        chk("stall_hold_kind", int'(cfg_bus.cfg_kind), held.kind);
        chk("stall_hold_row",  int'(cfg_bus.cfg_row),  held.row);
        chk("stall_hold_col",  int'(cfg_bus.cfg_col),  held.col);
        chk("stall_hold_data", int'(cfg_bus.cfg_data), held.data);
      end
      stalled = 0;
      if (cfg_bus.cfg_valid) begin
        if (c == 1 || c == exp_n) chk("busy_with_valid", int'(busy), 1);
        if (cfg_bus.cfg_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_write", hs + 1, exp_n);
          end else begin
            e = exp_q.pop_front();
            chk("wr_net",  int'(cfg_bus.cfg_net),  e.net);
            chk("wr_kind", int'(cfg_bus.cfg_kind), e.kind);
            chk("wr_row",  int'(cfg_bus.cfg_row),  e.row);
            chk("wr_col",  int'(cfg_bus.cfg_col),  e.col);
            chk("wr_data", int'(cfg_bus.cfg_data), e.data);
          end
          hs++;
        end else begin
          stalls++;
          stalled = 1;
          held = '{int'(cfg_bus.cfg_net), int'(cfg_bus.cfg_kind), int'(cfg_bus.cfg_row),
                   int'(cfg_bus.cfg_col), int'(cfg_bus.cfg_data)};
        end
      end
      if (done) begin
        chk("write_count", hs, exp_n);
        chk("done_cycle", c, exp_n + stalls + 1);
        chk("busy_in_done", int'(busy), 0);
        chk("valid_in_done", int'(cfg_bus.cfg_valid), 0);
        fin_seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!fin_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d writes, expected %0d then done", hs, exp_n);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_valid", int'(cfg_bus.cfg_valid), 0);
    chk("idle_after_busy", int'(busy), 0);
    chk("idle_after_done", int'(done), 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [9];

  initial begin
    int hs;
    bit got_done;
    vecs[0] = '{h: 6, w: 8,  mode: 0, exp_n: 217, poke: 0};
    vecs[1] = '{h: 1, w: 4,  mode: 0, exp_n: 21,  poke: 0};
    vecs[2] = '{h: 6, w: 8,  mode: 1, exp_n: 217, poke: 0};
    vecs[3] = '{h: 7, w: 12, mode: 0, exp_n: 217, poke: 0};
    vecs[4] = '{h: 6, w: 0,  mode: 0, exp_n: 1,   poke: 0};
    vecs[5] = '{h: 0, w: 5,  mode: 1, exp_n: 1,   poke: 0};
    vecs[6] = '{h: 3, w: 5,  mode: 1, exp_n: 73,  poke: 0};
    vecs[7] = '{h: 2, w: 1,  mode: 0, exp_n: 17,  poke: 0};
    vecs[8] = '{h: 6, w: 8,  mode: 0, exp_n: 217, poke: 1};

    cfg_bus.cfg_ready = 1'b0;
    rand_tables();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      rand_tables();
      run_seq(vecs[i].h, vecs[i].w, vecs[i].mode, vecs[i].exp_n, vecs[i].poke, 0);
    end

    // Reset while write 100 is being presented.
    rand_tables();
    array_h = 3'd6;
    array_w = 4'd8;
    cfg_bus.cfg_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 400 && hs < 100; c++) begin
      @(negedge clk);
      if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) hs++;
      if (hs < 100) begin
        @(posedge clk); #1;
      end
    end
    chk("reset_point_reached", hs, 100);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    got_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    chk("midrst_no_done", int'(got_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_tables();
    run_seq(6, 8, 0, 217, 0, 0);

`ifdef ID_SNAPSHOT_EN
    rand_tables();
    run_seq(6, 8, 1, 217, 0, 50);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
